// File: rtl/tb_bank_writer_if.sv
// Pixel stream in, bank write port out, plus block status for the template-store loader.
// The loader takes the slave side; the pixel source or bench takes the master side.
interface tb_bank_writer_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 6
);
    logic              start;
    logic [DWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [3:0]        wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, in_data, in_valid, in_last,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  start, in_data, in_valid, in_last,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/tb_bank_writer.sv
// Loads a 16x16 template block into the four interleaved banks A/B/C/D so that
// a pixel read at raster address p returns the pixel streamed in at index p.
module tb_bank_writer #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 6
) (
    input logic             clk,
    input logic             rst,
    tb_bank_writer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        pix_cnt_q, pix_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [3:0]        wr_en_q, wr_en_d;
    logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DWIDTH-1:0] wr_data_q, wr_data_d;
    logic              accept;
    logic              last_pix;

    assign accept   = (state_q == StLoad) && bus.in_valid && in_ready_q;
    assign last_pix = (pix_cnt_q == 8'hFF);

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        err_d     = err_q;
        wr_en_d   = 4'b0000;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StLoad;
                    pix_cnt_d = 8'd0;
                    err_d     = 1'b0;
                end
            end
            StLoad: begin
                if (accept) begin
                    // Bank {p[4],p[0]} and address {p[7:5],p[3:1]} match the pixel-read decode.
                    wr_en_d   = 4'b1000 >> {pix_cnt_q[4], pix_cnt_q[0]};
                    wr_addr_d = AWIDTH'({pix_cnt_q[7:5], pix_cnt_q[3:1]});
                    wr_data_d = bus.in_data;
                    if (bus.in_last != last_pix) begin
                        err_d = 1'b1;
                    end
                    if (last_pix) begin
                        state_d = StDone;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 8'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        in_ready_d = (state_d == StLoad);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pix_cnt_q  <= 8'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 4'b0000;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
endmodule

// File: tb/tb_tb_bank_writer.sv
// Directed bench for the template-block bank loader: vector table on write mapping,
// hand-written sequences for reset, stalls, framing errors and readback.
module tb_tb_bank_writer;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tb_bank_writer_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    tb_bank_writer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] p;
        logic [3:0] en;
        logic [5:0] addr;
        logic       done;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    int         log_n    = 0;
    bit         exp_err  = 1'b0;
    logic [3:0] log_en   [256];
    logic [5:0] log_addr [256];
    logic [7:0] log_data [256];
    logic       log_done [256];
    logic [3:0] cont_en  [256];
    logic [5:0] cont_addr[256];
    logic [7:0] mem      [4][64];
    bit         seen     [4][64];
    vec_t       vecs     [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_en(input logic [7:0] p);
        case ({p[4], p[0]})
            2'b00:   return 4'b1000;
            2'b01:   return 4'b0100;
            2'b10:   return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic [5:0] exp_addr(input logic [7:0] p);
        return {p[7:5], p[3:1]};
    endfunction

    // One clock; acc says whether the bench expects pixel p (data d) accepted at this edge.
    task automatic tick(input bit acc, input logic [7:0] p, input logic [7:0] d);
        @(posedge clk);
        #1;
        if (acc) begin
            check("wr_en", 32'(bus.wr_en), 32'(exp_en(p)));
            check("wr_addr", 32'(bus.wr_addr), 32'(exp_addr(p)));
            check("wr_data", 32'(bus.wr_data), 32'(d));
        end else begin
            check("wr_en_quiet", 32'(bus.wr_en), 32'd0);
        end
        check("done", 32'(bus.done), 32'(acc && (p == 8'hFF)));
        if (bus.wr_en != 4'b0000) begin
            int b;
            b = bus.wr_en[3] ? 0 : bus.wr_en[2] ? 1 : bus.wr_en[1] ? 2 : 3;
            mem[b][bus.wr_addr]  = bus.wr_data;
            seen[b][bus.wr_addr] = 1'b1;
            if (log_n < 256) begin
                log_en[log_n]   = bus.wr_en;
                log_addr[log_n] = bus.wr_addr;
                log_data[log_n] = bus.wr_data;
                log_done[log_n] = bus.done;
            end
            log_n++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    endtask

    task automatic load_block(input logic [7:0] key, input int stall_pct, input int bad_idx,
                              input bit drop_last, input bit poke_start);
        int p   = 0;
        int cyc = 0;
        bit acc;
        bit in_load;
        bus.start = 1'b1;
        tick(1'b0, 8'd0, 8'd0);
        bus.start = 1'b0;
        exp_err   = 1'b0;
        in_load   = 1'b1;
        log_n     = 0;
        check("ready_after_start", 32'(bus.in_ready), 32'd1);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("err_cleared_by_start", 32'(bus.err), 32'd0);
        while (p < 256 && cyc < 5000) begin
            bus.in_valid = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            bus.in_data  = 8'(p) ^ key;
            bus.in_last  = (p == 255 && !drop_last) || (p == bad_idx);
            bus.start    = poke_start && (cyc % 7 == 3);
            acc          = bus.in_valid && in_load;
            if (acc && (bus.in_last != (p == 255))) exp_err = 1'b1;
            tick(acc, 8'(p), bus.in_data);
            check("err", 32'(bus.err), 32'(exp_err));
            if (acc) begin
                if (p == 255) in_load = 1'b0;
                p++;
            end
            check("in_ready", 32'(bus.in_ready), 32'(in_load));
            check("busy", 32'(bus.busy), 32'd1);
            cyc++;
        end
        bus.start   = 1'b0;
        bus.in_last = 1'b0;
        if (p < 256) begin
            checks++;
            failures++;
            $display("FAIL load_timeout: accepted %0d required 256", p);
        end
        check("write_count", 32'(log_n), 32'd256);
        // Valid held high through DONE and into IDLE must not write.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'd0, 8'd0);
            check("post_in_ready", 32'(bus.in_ready), 32'd0);
            check("post_busy", 32'(bus.busy), 32'd0);
            check("post_err_hold", 32'(bus.err), 32'(exp_err));
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{p: 8'd0,   en: 4'b1000, addr: 6'd0,  done: 1'b0};
        vecs[1]  = '{p: 8'd1,   en: 4'b0100, addr: 6'd0,  done: 1'b0};
        vecs[2]  = '{p: 8'd16,  en: 4'b0010, addr: 6'd0,  done: 1'b0};
        vecs[3]  = '{p: 8'd17,  en: 4'b0001, addr: 6'd0,  done: 1'b0};
        vecs[4]  = '{p: 8'd255, en: 4'b0001, addr: 6'd63, done: 1'b1};
        vecs[5]  = '{p: 8'd2,   en: 4'b1000, addr: 6'd1,  done: 1'b0};
        vecs[6]  = '{p: 8'd34,  en: 4'b1000, addr: 6'd9,  done: 1'b0};
        vecs[7]  = '{p: 8'd100, en: 4'b1000, addr: 6'd26, done: 1'b0};
        vecs[8]  = '{p: 8'd200, en: 4'b1000, addr: 6'd52, done: 1'b0};
        vecs[9]  = '{p: 8'd219, en: 4'b0001, addr: 6'd53, done: 1'b0};
        vecs[10] = '{p: 8'd63,  en: 4'b0001, addr: 6'd15, done: 1'b0};
        vecs[11] = '{p: 8'd129, en: 4'b0100, addr: 6'd32, done: 1'b0};
        vecs[12] = '{p: 8'd144, en: 4'b0010, addr: 6'd32, done: 1'b0};
        vecs[13] = '{p: 8'd145, en: 4'b0001, addr: 6'd32, done: 1'b0};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tick(1'b0, 8'd0, 8'd0);
        tick(1'b0, 8'd0, 8'd0);
        check_zero("reset");
        rst = 1'b0;

        // Partial load of 10 pixels, then a 3-cycle reset; the last reset cycle also has start.
        bus.start = 1'b1;
        tick(1'b0, 8'd0, 8'd0);
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i) + 8'hA0;
            tick(1'b1, 8'(i), bus.in_data);
            check("partial_in_ready", 32'(bus.in_ready), 32'd1);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.start = (i == 2);
            tick(1'b0, 8'd0, 8'd0);
            check_zero("mid_reset");
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 8'd0, 8'd0);
            check_zero("after_reset");
        end
        bus.in_valid = 1'b0;

        // Continuous block, in_data = p; reload begins at p=0 after the abandoned block.
        load_block(8'h00, 0, -1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            check("vec_wr_en", 32'(log_en[vecs[i].p]), 32'(vecs[i].en));
            check("vec_wr_addr", 32'(log_addr[vecs[i].p]), 32'(vecs[i].addr));
            check("vec_wr_data", 32'(log_data[vecs[i].p]), 32'(vecs[i].p));
            check("vec_done", 32'(log_done[vecs[i].p]), 32'(vecs[i].done));
        end
        for (int i = 0; i < 256; i++) begin
            cont_en[i]   = log_en[i];
            cont_addr[i] = log_addr[i];
        end

        // Readback through word and pixel views after a keyed load.
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++) seen[b][a] = 1'b0;
        load_block(8'h5A, 0, -1, 1'b0, 1'b0);
        for (int a = 0; a < 64; a++) begin
            logic [5:0]  aa;
            logic [31:0] word_exp;
            aa = 6'(a);
            for (int s = 0; s < 4; s++) begin
                logic [1:0] ss;
                logic [7:0] pp;
                ss = 2'(s);
                pp = {aa[5:3], ss[1], aa[2:0], ss[0]};
                word_exp[31 - 8 * s -: 8] = pp ^ 8'h5A;
            end
            check("word_read", {mem[0][a], mem[1][a], mem[2][a], mem[3][a]}, word_exp);
        end
        for (int p = 0; p < 256; p++) begin
            logic [7:0] pp;
            int         b;
            pp = 8'(p);
            b  = int'({pp[4], pp[0]});
            check("pixel_written", 32'(seen[b][{pp[7:5], pp[3:1]}]), 32'd1);
            check("pixel_read", 32'(mem[b][{pp[7:5], pp[3:1]}]), 32'(pp ^ 8'h5A));
        end

        // ~50% stalls with start pokes during LOAD; address sequence must match continuous run.
        load_block(8'h33, 50, -1, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            check("stall_seq_en", 32'(log_en[i]), 32'(cont_en[i]));
            check("stall_seq_addr", 32'(log_addr[i]), 32'(cont_addr[i]));
        end

        // Framing: early in_last, then missing in_last, then a clean block clears err.
        load_block(8'h00, 0, 100, 1'b0, 1'b0);
        check("err_early_last", 32'(bus.err), 32'd1);
        load_block(8'h00, 0, -1, 1'b1, 1'b0);
        check("err_missing_last", 32'(bus.err), 32'd1);
        load_block(8'h00, 0, -1, 1'b0, 1'b0);
        check("err_clean_block", 32'(bus.err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tb_bank_writer.md
Name: tb_bank_writer

Overview:
- Write-side loader for the four-bank interleaved template-block store. The read side of that store returns one 32-bit word {A,B,C,D} per 6-bit address, or one pixel per 8-bit raster address.
- Accepts a 16x16 template block (256 pixels, raster order) as a valid/ready pixel stream.
- Routes each pixel to bank A/B/C/D and the bank address that the pixel-read path decodes, so the readback mapping is identical.
- Sits between the pixel source (host/DMA/bench feeder) and the write ports of the four memory_dual_port banks.

Parameters:
- DWIDTH, 8, pixel width; also the width of wr_data.
- AWIDTH, 6, bank address width. Fixed at 6 for the 256-pixel block; other values are not supported.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins loading a block
- in_data  input  DWIDTH  pixel value
- in_valid  input  1  in_data valid
- in_last  input  1  source marks final pixel of block
- in_ready  output  1  block accepts a pixel this cycle
- wr_en  output  4  one-hot bank write enable, bit3=A bit2=B bit1=C bit0=D
- wr_addr  output  AWIDTH  bank write address, shared by all banks
- wr_data  output  DWIDTH  bank write data, shared by all banks
- busy  output  1  high in LOAD and DONE
- done  output  1  one-cycle pulse, block fully written
- err  output  1  sticky framing error, cleared by start or rst

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, pix_cnt=0; in_ready, wr_en, busy, done and err all 0; wr_addr=0, wr_data=0.
  - Reset mid-LOAD abandons the block. No further writes occur, and the partial bank contents are left as written.
- FSM states IDLE, LOAD, DONE:
  - IDLE: in_ready=0. On start=1, go to LOAD, set pix_cnt=0 and err=0.
  - LOAD: in_ready=1. A pixel is accepted when in_valid && in_ready.
  - On accept with pix_cnt==255, go to DONE; otherwise increment pix_cnt (8-bit).
  - DONE: lasts one cycle with in_ready=0 and done=1, then returns to IDLE.
  - start is ignored in LOAD and DONE.
- Address mapping for an accepted pixel with raster index p=pix_cnt[7:0]:
  - bank select = {p[4],p[0]}: 00 selects A, 01 selects B, 10 selects C, 11 selects D.
  - wr_addr = {p[7:5], p[3:1]}.
- Write latency: registered, exactly 1 cycle after accept.
  - In the cycle after an accept, wr_en has exactly the selected bit set, and wr_addr and wr_data carry the accepted pixel.
  - In every other cycle wr_en=0. wr_addr and wr_data hold their last values.
  - The 256th write is presented in the same cycle as done=1, in state DONE.
- Throughput: one pixel per cycle sustained. A stall (in_valid=0) produces no write and leaves pix_cnt unchanged.
- in_last checks, sampled only on accept:
  - in_last=1 with pix_cnt!=255: set err=1, still write the pixel, continue counting.
  - in_last=0 with pix_cnt==255: set err=1, block still completes.
  - err stays high until the next start or rst.
- Boundaries:
  - pix_cnt never wraps within a block, because DONE follows index 255.
  - start and rst asserted together: rst wins.
  - in_valid while in IDLE or DONE is ignored, with no write and no count change.
- Readback invariant: a pixel at raster index p, read back through the 8-bit pixel port at address p, returns the written value.

Test Plan:
- Reset check: hold rst for 3 cycles mid-LOAD after 10 pixels -> all outputs 0, state IDLE, no wr_en pulse afterwards. A new start reloads from p=0.
- Full block, continuous valid: start, then 256 pixels with in_data=p and in_last on p=255.
  - p=0: wr_en=1000, wr_addr=0.
  - p=1: wr_en=0100, wr_addr=0.
  - p=16: wr_en=0010, wr_addr=0.
  - p=17: wr_en=0001, wr_addr=0.
  - p=255: wr_en=0001, wr_addr=63, coincident with done=1.
  - err=0 throughout.
- Readback: after a full load with in_data=p^8'h5A, read all 64 word addresses and all 256 pixel addresses through the read path -> every value matches.
- Backpressure/stalls: random in_valid gaps (~50%) -> exactly 256 one-hot writes, each one cycle after its accept, with an identical address sequence to the continuous case.
- Framing errors:
  - in_last on p=100 -> err=1 from the following cycle; the load still finishes at p=255 with done=1.
  - A second block with in_last missing on p=255 -> err=1.
  - A following start clears err.
- Ignored inputs: start pulses during LOAD and in_valid pulses during IDLE/DONE -> no restart, no extra writes, pix_cnt sequence unchanged.
